// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: derives round keys 0..10 into a register file read by index.
// Define AES_KS_COMB_SBOX_EN for a combinational S-box and one round key per cycle.
module aes_key_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, SUB, EXP, DONE} state_t;

`ifdef AES_KS_COMB_SBOX_EN
    localparam state_t FIRST_ST = EXP;
`else
    localparam state_t FIRST_ST = SUB;
`endif

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[(255 - int'(a)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rcon advance in GF(2^8); 80 wraps to 1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     round_q;
    logic [7:0]     rcon_q;
    logic [127:0]   prev_q;
    logic [127:0]   slot_q [0:10];
    logic           load, expand;
    logic [31:0]    rot_word, sw, t;
    logic [31:0]    k0, k1, k2, k3;
    logic [127:0]   next_key;

    assign rot_word = {prev_q[23:0], prev_q[31:24]};

`ifdef AES_KS_COMB_SBOX_EN
    assign sw = sub_word(rot_word);
`else
    // ROM-style lookup: address presented in SUB, data consumed in EXP.
    logic [31:0] sw_q;
    always_ff @(posedge clk) begin
        sw_q <= sub_word(rot_word);
    end
    assign sw = sw_q;
`endif

    assign t        = sw ^ {rcon_q, 24'h0};
    assign k0       = prev_q[127:96] ^ t;
    assign k1       = prev_q[95:64]  ^ k0;
    assign k2       = prev_q[63:32]  ^ k1;
    assign k3       = prev_q[31:0]   ^ k2;
    assign next_key = {k0, k1, k2, k3};

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        expand  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = FIRST_ST;
                end
            end
            SUB: state_d = EXP;
            EXP: begin
                expand  = 1'b1;
                state_d = (round_q == 4'd10) ? DONE : FIRST_ST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            for (int i = 0; i <= 10; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                slot_q[0] <= key;
                round_q   <= 4'd1;
                rcon_q    <= 8'h01;
            end else if (expand) begin
                slot_q[round_q] <= next_key;
                if (round_q != 4'd10) begin
                    round_q <= round_q + 4'd1;
                    rcon_q  <= xtime(rcon_q);
                end
            end
        end
    end

    // Working key register; only meaningful while an expansion runs.
    always_ff @(posedge clk) begin
        if (load)        prev_q <= key;
        else if (expand) prev_q <= next_key;
    end

    assign busy       = (state_q == SUB) || (state_q == EXP);
    assign keys_valid = (state_q == DONE);

    always_comb begin
        rd_key = '0;
        if (rd_round <= 4'd10) rd_key = slot_q[rd_round];
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using FIPS-197 App. A and App. C vectors.
module tb_aes_key_schedule;
`ifdef AES_KS_COMB_SBOX_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 20;
`endif

    logic         clk = 1'b0;
    logic         reset, start, busy, keys_valid;
    logic [127:0] key, rd_key;
    logic [3:0]   rd_round;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] val;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    logic [127:0] rk_a [0:10];

    aes_key_schedule dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .busy(busy), .keys_valid(keys_valid),
        .rd_round(rd_round), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] r, input logic [127:0] v);
        exp_t e;
        e.rnd = r;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic push_a();
        for (int i = 0; i <= 10; i++) push_exp(4'(i), rk_a[i]);
    endtask

    // Start accepted at the following edge E0; returns at E0 + 1ns.
    task automatic accept(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Counts edges after E0 until keys_valid; optionally pulses start at edge E0+inject_at.
    task automatic wait_done(input int inject_at, input logic [127:0] k2);
        int n = 0;
        while (n < 60 && !keys_valid) begin
            if (n + 1 == inject_at) begin
                start = 1'b1;
                key   = k2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check_val("latency", 128'(n), 128'(LAT));
        check_val("busy_done", 128'(busy), 128'd0);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rd_round = e.rnd;
            #1;
            check_val($sformatf("rk%0d", e.rnd), rd_key, e.val);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_busy"}, 128'(busy), 128'd0);
        check_val({tag, "_kv"}, 128'(keys_valid), 128'd0);
        for (int r = 0; r <= 10; r += 5) begin
            rd_round = 4'(r);
            #1;
            check_val($sformatf("%s_rk%0d", tag, r), rd_key, 128'd0);
        end
    endtask

    initial begin
        rk_a[0]  = KEY_A;
        rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b1; start = 1'b0; key = '0; rd_round = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        // App. A with an ignored start at E0+7.
        accept(KEY_A);
        check_val("busy_e0", 128'(busy), 128'd1);
        check_val("kv_e0", 128'(keys_valid), 128'd0);
        rd_round = 4'd0;
        #1;
        check_val("slot0_e0", rd_key, KEY_A);
        push_a();
        wait_done(7, KEY_C);
        drain();

        // Restart from DONE with App. C.
        accept(KEY_C);
        check_val("kv_drop", 128'(keys_valid), 128'd0);
        push_exp(4'd0, KEY_C);
        push_exp(4'd10, C_R10);
        wait_done(-1, '0);
        drain();
        rd_round = 4'd11;
        #1;
        check_val("rd11", rd_key, 128'd0);
        rd_round = 4'd15;
        #1;
        check_val("rd15", rd_key, 128'd0);

        // Reset sampled at E0+9 aborts, then a fresh start completes.
        accept(KEY_A);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("abort");
        accept(KEY_A);
        push_a();
        wait_done(-1, '0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
